// File: rtl/pc_next_unit_pkg.sv
// Shared constants and helpers for the next-PC unit: opcode/funct encodings,
// status flag bit positions, and the target-path selection type.
package pc_next_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Primary opcodes
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BALV    = 6'b100000;
    localparam logic [5:0] OP_BLEZAL  = 6'b100100;
    localparam logic [5:0] OP_JALPC   = 6'b011111;
    localparam logic [5:0] OP_NANDI   = 6'b010000;

    // R-format funct codes
    localparam logic [5:0] FUNCT_BRV   = 6'b010100;
    localparam logic [5:0] FUNCT_JMXOR = 6'b100010;

    // Bit positions inside the 3-bit {Z,N,V} status register
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    // Which source drives next_pc this cycle, in priority order (highest last)
    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BEQ,
        SEL_BLEZAL,
        SEL_BALV,
        SEL_JALPC,
        SEL_BRV,
        SEL_JMXOR
    } pc_sel_e;

    // Word offset of a PC-relative branch: sign-extended immediate times four
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_unit_target_gen.sv
// Purely combinational target arithmetic: PC-relative branch target,
// pseudo-direct jump target, and the XOR pointer used by jmxor.
module pc_target_gen
    import pc_next_unit_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [15:0] imm16,
    input  logic [25:0] jaddr26,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [31:0] branch_target,
    output logic [31:0] pseudo_target,
    output logic [31:0] xor_ptr
);

    // Target arithmetic; no state, no priority decisions
    always_comb begin
        branch_target = pc_plus4 + branch_offset(imm16);
        pseudo_target = {pc_plus4[31:28], jaddr26, 2'b00};
        xor_ptr       = rs_data ^ rt_data;
    end

endmodule

// File: rtl/pc_next_unit.sv
// Next-PC unit: holds the PC and {Z,N,V} status, picks the next fetch
// address by fixed priority, and generates the link-register write.
module pc_next_unit
    import pc_next_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [4:0]  LINK_REG = 5'd31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic        regdest,
    input  logic        branch,
    input  logic        brvsig,
    input  logic        jmxorsig,
    input  logic        blezalsig,
    input  logic        balvsig,
    input  logic        jalpcsig,
    input  logic [15:0] imm16,
    input  logic [25:0] jaddr26,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] mem_rdata,
    input  logic        alu_zero,
    input  logic        alu_neg,
    input  logic        alu_ovf,
    input  logic        flag_we,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output logic [31:0] mem_addr,
    output logic        link_we,
    output logic [4:0]  link_addr,
    output logic [31:0] link_data,
    output logic        taken,
    output logic [2:0]  status,
    output logic        align_err
);

    logic [31:0] pc_q, pc_d;
    logic [2:0]  status_q, status_d;
    logic        align_err_q, align_err_d;

    logic [31:0] branch_target, pseudo_target, xor_ptr;
    logic        brv_en, jmxor_en, rs_le_zero;
    logic        link_req;
    pc_sel_e     sel;

    assign pc_plus4 = pc_q + 32'd4;

    pc_target_gen u_target_gen (
        .pc_plus4      (pc_plus4),
        .imm16         (imm16),
        .jaddr26       (jaddr26),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .branch_target (branch_target),
        .pseudo_target (pseudo_target),
        .xor_ptr       (xor_ptr)
    );

    // brv and jmxor are funct-encoded, so they only count on R-format words
    assign brv_en     = brvsig & regdest;
    assign jmxor_en   = jmxorsig & regdest;
    assign rs_le_zero = rs_data[31] | (rs_data == 32'd0);

    // Priority select of the active control-transfer source
    always_comb begin
        sel = SEL_SEQ;
        if (jmxor_en)       sel = SEL_JMXOR;
        else if (brv_en)    sel = SEL_BRV;
        else if (jalpcsig)  sel = SEL_JALPC;
        else if (balvsig)   sel = SEL_BALV;
        else if (blezalsig) sel = SEL_BLEZAL;
        else if (branch)    sel = SEL_BEQ;
    end

    // Next PC, taken and link request; conditions read the registered status
    always_comb begin
        next_pc  = pc_plus4;
        taken    = 1'b0;
        link_req = 1'b0;
        case (sel)
            SEL_JMXOR: begin
                next_pc  = mem_rdata;
                taken    = 1'b1;
                link_req = 1'b1;
            end
            SEL_BRV: begin
                if (status_q[FLAG_V]) begin
                    next_pc = rs_data;
                    taken   = 1'b1;
                end
            end
            SEL_JALPC: begin
                next_pc  = branch_target;
                taken    = 1'b1;
                link_req = 1'b1;
            end
            SEL_BALV: begin
                if (status_q[FLAG_V]) begin
                    next_pc  = pseudo_target;
                    taken    = 1'b1;
                    link_req = 1'b1;
                end
            end
            SEL_BLEZAL: begin
                if (rs_le_zero) begin
                    next_pc  = branch_target;
                    taken    = 1'b1;
                    link_req = 1'b1;
                end
            end
            SEL_BEQ: begin
                if (alu_zero) begin
                    next_pc = branch_target;
                    taken   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // A stalled slot must never write the register file
    always_comb begin
        link_we   = link_req & instr_valid;
        link_addr = LINK_REG;
        link_data = pc_plus4;
        mem_addr  = xor_ptr;
    end

    // Commit values; the PC is always forced word-aligned, misalignment is sticky
    always_comb begin
        pc_d        = {next_pc[31:2], 2'b00};
        status_d    = flag_we ? {alu_zero, alu_neg, alu_ovf} : status_q;
        align_err_d = align_err_q | (next_pc[1:0] != 2'b00);
    end

    // State register: reset dominates, a stall holds everything
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            status_q    <= 3'b000;
            align_err_q <= 1'b0;
        end else if (instr_valid) begin
            pc_q        <= pc_d;
            status_q    <= status_d;
            align_err_q <= align_err_d;
        end
    end

    assign pc        = pc_q;
    assign status    = status_q;
    assign align_err = align_err_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: stimulus pushes expectations into a
// scoreboard queue, a negedge monitor pops and compares them.
module tb_pc_next_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        regdest, branch, brvsig, jmxorsig, blezalsig, balvsig, jalpcsig;
    logic [15:0] imm16;
    logic [25:0] jaddr26;
    logic [31:0] rs_data, rt_data, mem_rdata;
    logic        alu_zero, alu_neg, alu_ovf, flag_we;
    logic [31:0] pc, pc_plus4, next_pc, mem_addr, link_data;
    logic        link_we, taken, align_err;
    logic [4:0]  link_addr;
    logic [2:0]  status;

    localparam int S_PC = 0, S_PC4 = 1, S_NPC = 2, S_MADDR = 3, S_LWE = 4,
                   S_LADDR = 5, S_LDATA = 6, S_TAKEN = 7, S_STATUS = 8, S_ALIGN = 9;

    string       q_name[$];
    int          q_sel[$];
    logic [31:0] q_exp[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_next_unit dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid),
        .regdest(regdest), .branch(branch), .brvsig(brvsig), .jmxorsig(jmxorsig),
        .blezalsig(blezalsig), .balvsig(balvsig), .jalpcsig(jalpcsig),
        .imm16(imm16), .jaddr26(jaddr26),
        .rs_data(rs_data), .rt_data(rt_data), .mem_rdata(mem_rdata),
        .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_ovf(alu_ovf), .flag_we(flag_we),
        .pc(pc), .pc_plus4(pc_plus4), .next_pc(next_pc), .mem_addr(mem_addr),
        .link_we(link_we), .link_addr(link_addr), .link_data(link_data),
        .taken(taken), .status(status), .align_err(align_err)
    );

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_PC:     return pc;
            S_PC4:    return pc_plus4;
            S_NPC:    return next_pc;
            S_MADDR:  return mem_addr;
            S_LWE:    return {31'd0, link_we};
            S_LADDR:  return {27'd0, link_addr};
            S_LDATA:  return link_data;
            S_TAKEN:  return {31'd0, taken};
            S_STATUS: return {29'd0, status};
            S_ALIGN:  return {31'd0, align_err};
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: compare every expectation queued for the current cycle
    always @(negedge clk) begin
        while (q_sel.size() > 0) begin
            string       n;
            int          s;
            logic [31:0] e, a;
            n = q_name.pop_front();
            s = q_sel.pop_front();
            e = q_exp.pop_front();
            a = observe(s);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", n, a, e);
            end
        end
    end

    task automatic expect_val(input string n, input int sel, input logic [31:0] v);
        q_name.push_back(n);
        q_sel.push_back(sel);
        q_exp.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        instr_valid = 1'b1;
        {regdest, branch, brvsig, jmxorsig, blezalsig, balvsig, jalpcsig} = '0;
        imm16 = '0; jaddr26 = '0;
        rs_data = 32'd1; rt_data = '0; mem_rdata = '0;
        {alu_zero, alu_neg, alu_ovf, flag_we} = '0;
    endtask

    task automatic expect_flow(input string n, input logic [31:0] p, input logic [31:0] np,
                               input logic tk, input logic lwe);
        expect_val({n, "_pc"}, S_PC, p);
        expect_val({n, "_next_pc"}, S_NPC, np);
        expect_val({n, "_taken"}, S_TAKEN, {31'd0, tk});
        expect_val({n, "_link_we"}, S_LWE, {31'd0, lwe});
    endtask

    initial begin
        idle();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;

        // Reset state and sequential fetch
        expect_val("rst_status", S_STATUS, 32'd0);
        expect_val("rst_align", S_ALIGN, 32'd0);
        for (int i = 0; i < 4; i++) begin
            expect_flow($sformatf("seq%0d", i), 32'(4 * i), 32'(4 * i + 4), 1'b0, 1'b0);
            step();
        end

        // pc=0x10: ovf written in the same cycle as balv is not yet visible
        flag_we = 1'b1; alu_ovf = 1'b1; balvsig = 1'b1; jaddr26 = 26'h40;
        expect_flow("balv_same", 32'h10, 32'h14, 1'b0, 1'b0);
        step();
        idle(); balvsig = 1'b1; jaddr26 = 26'h40;
        expect_flow("balv", 32'h14, 32'h100, 1'b1, 1'b1);
        expect_val("balv_status", S_STATUS, 32'b001);
        expect_val("balv_ldata", S_LDATA, 32'h18);
        expect_val("balv_laddr", S_LADDR, 32'd31);
        step();

        // brv without regdest is ignored (stalled so nothing commits)
        idle(); instr_valid = 1'b0; brvsig = 1'b1; rs_data = 32'h200;
        expect_flow("brv_unq", 32'h100, 32'h104, 1'b0, 1'b0);
        step();
        idle(); brvsig = 1'b1; regdest = 1'b1; rs_data = 32'h200;
        flag_we = 1'b1; alu_zero = 1'b1;
        expect_flow("brv", 32'h100, 32'h200, 1'b1, 1'b0);
        step();

        // jalpc back to 0x40: 0x204 + sext(0xFF8F)<<2
        idle(); jalpcsig = 1'b1; imm16 = 16'hFF8F;
        expect_flow("jalpc", 32'h200, 32'h40, 1'b1, 1'b1);
        expect_val("jalpc_ldata", S_LDATA, 32'h204);
        expect_val("jalpc_status", S_STATUS, 32'b100);
        step();

        // beq at 0x40
        idle(); instr_valid = 1'b0; branch = 1'b1; imm16 = 16'hFFFE;
        expect_flow("beq_nt", 32'h40, 32'h44, 1'b0, 1'b0);
        step();
        idle(); branch = 1'b1; alu_zero = 1'b1; imm16 = 16'hFFFE;
        expect_flow("beq_t", 32'h40, 32'h3C, 1'b1, 1'b0);
        step();

        // blezal: rs=1 not taken, rs=0 and rs=-1 taken
        idle(); blezalsig = 1'b1; imm16 = 16'h0010; rs_data = 32'd1;
        expect_flow("blez_pos", 32'h3C, 32'h40, 1'b0, 1'b0);
        step();
        idle(); blezalsig = 1'b1; imm16 = 16'h0010; rs_data = 32'd0;
        expect_flow("blez_zero", 32'h40, 32'h84, 1'b1, 1'b1);
        expect_val("blez_zero_ldata", S_LDATA, 32'h44);
        step();
        idle(); blezalsig = 1'b1; imm16 = 16'h0010; rs_data = 32'hFFFF_FFFF;
        expect_flow("blez_neg", 32'h84, 32'hC8, 1'b1, 1'b1);
        step();

        // Three stalled cycles with jalpc and a flag write pending
        for (int i = 0; i < 3; i++) begin
            idle(); instr_valid = 1'b0; jalpcsig = 1'b1; imm16 = 16'h0004;
            flag_we = 1'b1; alu_ovf = 1'b1;
            expect_flow($sformatf("stall%0d", i), 32'hC8, 32'hDC, 1'b1, 1'b0);
            expect_val($sformatf("stall%0d_status", i), S_STATUS, 32'b100);
            step();
        end

        // jmxor beats every lower-priority source; misaligned target
        idle(); regdest = 1'b1; jmxorsig = 1'b1; jalpcsig = 1'b1; branch = 1'b1;
        alu_zero = 1'b1; rs_data = 32'h1000; rt_data = 32'h0F00; mem_rdata = 32'h2002;
        expect_flow("jmxor", 32'hC8, 32'h2002, 1'b1, 1'b1);
        expect_val("jmxor_maddr", S_MADDR, 32'h1F00);
        expect_val("jmxor_ldata", S_LDATA, 32'hCC);
        expect_val("jmxor_align0", S_ALIGN, 32'd0);
        step();
        idle();
        expect_val("post_jmxor_pc", S_PC, 32'h2000);
        expect_val("align_set", S_ALIGN, 32'd1);
        step();
        expect_val("align_sticky", S_ALIGN, 32'd1);
        expect_val("align_pc", S_PC, 32'h2004);
        step();

        // Reset during a stall with a jump pending
        idle(); instr_valid = 1'b0; jalpcsig = 1'b1; imm16 = 16'h0100; reset = 1'b1;
        step();
        reset = 1'b0; idle();
        expect_val("rst2_pc", S_PC, 32'h0);
        expect_val("rst2_align", S_ALIGN, 32'd0);
        expect_val("rst2_status", S_STATUS, 32'd0);
        jalpcsig = 1'b1; imm16 = 16'hFFFE;
        expect_val("wrap_jump", S_NPC, 32'hFFFF_FFFC);
        step();
        idle();
        expect_val("wrap_pc", S_PC, 32'hFFFF_FFFC);
        expect_val("wrap_pc4", S_PC4, 32'h0);
        expect_val("wrap_npc", S_NPC, 32'h0);
        step();
        step();

        if (q_sel.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q_sel.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_next_unit.md
PC_NEXT_UNIT -- requirements
Module: pc_next_unit

Interface
REQ-001 SHALL have parameters: RESET_PC, 32'h0000_0000, PC value after reset; LINK_REG, 5'd31, register number written by link instructions.
REQ-002 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have ports: reset  in  1  synchronous, active-high.
REQ-004 SHALL have ports: instr_valid  in  1  current instruction valid; low = stall, no state change.
REQ-005 SHALL have ports: regdest, branch, brvsig, jmxorsig, blezalsig, balvsig, jalpcsig  in  1 each  decoded control signals.
REQ-006 SHALL have ports: imm16  in  16  instruction immediate; jaddr26  in  26  instruction target field.
REQ-007 SHALL have ports: rs_data, rt_data  in  32  register operands; mem_rdata  in  32  data-memory read word.
REQ-008 SHALL have ports: alu_zero, alu_neg, alu_ovf  in  1  ALU result flags; flag_we  in  1  flag update request.
REQ-009 SHALL have ports: pc, pc_plus4, next_pc  out  32; mem_addr  out  32  jmxor pointer (rs_data XOR rt_data).
REQ-010 SHALL have ports: link_we  out  1; link_addr  out  5; link_data  out  32; taken  out  1; status  out  3 {Z,N,V}; align_err  out  1.

Function
REQ-011 SHALL hold PC register; pc_plus4 = pc + 4, modulo 2^32 (wrap, no flag).
REQ-012 SHALL qualify brvsig and jmxorsig with regdest (R-format); unqualified ones are ignored.
REQ-013 SHALL select next_pc by fixed priority: jmxor > brv > jalpc > balv > blezal > beq > pc_plus4.
REQ-014 jmxor: next_pc = mem_rdata; link taken; taken=1.
REQ-015 brv: if status.V then next_pc = rs_data, taken=1; else pc_plus4; never links.
REQ-016 jalpc: next_pc = pc_plus4 + (sext(imm16) << 2); link taken; taken=1.
REQ-017 balv: if status.V then next_pc = {pc_plus4[31:28], jaddr26, 2'b00}, link, taken=1; else pc_plus4, no link.
REQ-018 blezal: if rs_data signed <= 0 then next_pc = pc_plus4 + (sext(imm16) << 2), link, taken=1; else pc_plus4, no link.
REQ-019 beq: if alu_zero then next_pc = pc_plus4 + (sext(imm16) << 2), taken=1.
REQ-020 Link: link_we=1, link_addr=LINK_REG, link_data=pc_plus4; link_we SHALL be 0 when instr_valid=0.
REQ-021 Conditions SHALL use registered status (previous instruction); flag update from the same instruction is not visible until next cycle.
REQ-022 On rising edge with instr_valid=1: pc <= {next_pc[31:2], 2'b00}; if flag_we, status <= {alu_zero, alu_neg, alu_ovf}.
REQ-023 If next_pc[1:0] != 0 at a commit, align_err SHALL set (sticky); PC takes aligned value.
REQ-024 instr_valid=0: pc, status, align_err hold; next_pc/taken still computed combinationally.
REQ-025 Single-cycle: next_pc, taken, link outputs combinational from current inputs and state; zero-cycle latency.

Reset
REQ-026 On reset edge: pc=RESET_PC, status=3'b000, align_err=0; reset overrides instr_valid and flag_we.
REQ-027 Reset mid-stall or mid-branch SHALL discard pending target; first post-reset fetch at RESET_PC.

Structure
REQ-028 Shared package SHALL hold opcode/funct constants (beq 000100, balv 100000, blezal 100100, jalpc 011111, nandi 010000, brv funct 010100, jmxor funct 100010), flag bit indices Z=2,N=1,V=0, RESET_PC default.
REQ-029 One combinational sub-module pc_target_gen SHALL compute branch, pseudo-direct and XOR-pointer targets; state and priority stay in pc_next_unit.

Verification
REQ-030 Reset, then 4 valid sequential cycles -> pc 0,4,8,12; status 000; taken 0.
REQ-031 pc=0x40, beq, alu_zero=1, imm16=0xFFFE -> next_pc 0x3C, pc 0x3C next edge; alu_zero=0 -> 0x44.
REQ-032 flag_we with alu_ovf=1 at pc=0x10, next instr balv jaddr26=0x40 -> pc 0x100, link_data 0x18, link_addr 31; same-cycle ovf write plus balv -> not taken.
REQ-033 blezal rs_data=0 and 0xFFFFFFFF -> taken; rs_data=1 -> not taken, link_we 0.
REQ-034 jmxor rs=0x1000, rt=0x0F00 -> mem_addr 0x1F00; mem_rdata 0x2002 -> pc 0x2000, align_err 1 until reset.
REQ-035 instr_valid=0 for 3 cycles with jalpc asserted -> pc, status unchanged, link_we 0; reset during stall -> pc RESET_PC.
